writeback_arbiter: RTL and testbench

Shares the single two-port register-file writeback path between the FX, FP and Load/Store execution units. Each unit hands its result to the arbiter through a valid/ready handshake into a one-entry holding buffer. A round-robin arbiter picks one held result per cycle and drives the registered writeback outputs toward the register file and condition-register update logic. Sits between the execution units and the register file, replacing fixed-priority selection so that no unit can be starved.

---
 rtl/writeback_arbiter_if.sv | 76 +++++++
 rtl/writeback_arbiter.sv | 177 +++++++++++++++++
 tb/tb_writeback_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// Handshake and writeback bus between the FX/FP/LS execution units and the writeback arbiter.
// The master side is the execution units plus the register file; the slave side is the arbiter.
interface writeback_arbiter_if #(
    parameter int regWidth  = 6,
    parameter int dataWidth = 64
);
    logic                 FXValid_i;
    logic                 FXReady_o;
    logic                 FXReg1WritebackEnable_i;
    logic                 FXReg2WritebackEnable_i;
    logic [regWidth-1:0]  FXReg1WritebackAddress_i;
    logic [regWidth-1:0]  FXReg2WritebackAddress_i;
    logic [dataWidth-1:0] FXReg1WritebackValue_i;
    logic [dataWidth-1:0] FXReg2WritebackValue_i;

    logic                 FPValid_i;
    logic                 FPReady_o;
    logic                 FPReg1WritebackEnable_i;
    logic                 FPReg2WritebackEnable_i;
    logic [regWidth-1:0]  FPReg1WritebackAddress_i;
    logic [regWidth-1:0]  FPReg2WritebackAddress_i;
    logic [dataWidth-1:0] FPReg1WritebackValue_i;
    logic [dataWidth-1:0] FPReg2WritebackValue_i;

    logic                 LSValid_i;
    logic                 LSReady_o;
    logic                 LSReg1WritebackEnable_i;
    logic                 LSReg2WritebackEnable_i;
    logic [regWidth-1:0]  LSReg1WritebackAddress_i;
    logic [regWidth-1:0]  LSReg2WritebackAddress_i;
    logic [dataWidth-1:0] LSReg1WritebackValue_i;
    logic [dataWidth-1:0] LSReg2WritebackValue_i;

    logic                 writebackValid_o;
    logic [1:0]           functionalUnitCode_o;
    logic                 reg1WritebackEnable_o;
    logic                 reg2WritebackEnable_o;
    logic [regWidth-1:0]  reg1WritebackAddress_o;
    logic [regWidth-1:0]  reg2WritebackAddress_o;
    logic [dataWidth-1:0] reg1WritebackVal_o;
    logic [dataWidth-1:0] reg2WritebackVal_o;

    modport master (
        output FXValid_i, FXReg1WritebackEnable_i, FXReg2WritebackEnable_i,
               FXReg1WritebackAddress_i, FXReg2WritebackAddress_i,
               FXReg1WritebackValue_i, FXReg2WritebackValue_i,
        output FPValid_i, FPReg1WritebackEnable_i, FPReg2WritebackEnable_i,
               FPReg1WritebackAddress_i, FPReg2WritebackAddress_i,
               FPReg1WritebackValue_i, FPReg2WritebackValue_i,
        output LSValid_i, LSReg1WritebackEnable_i, LSReg2WritebackEnable_i,
               LSReg1WritebackAddress_i, LSReg2WritebackAddress_i,
               LSReg1WritebackValue_i, LSReg2WritebackValue_i,
        input  FXReady_o, FPReady_o, LSReady_o,
        input  writebackValid_o, functionalUnitCode_o,
               reg1WritebackEnable_o, reg2WritebackEnable_o,
               reg1WritebackAddress_o, reg2WritebackAddress_o,
               reg1WritebackVal_o, reg2WritebackVal_o
    );

    modport slave (
        input  FXValid_i, FXReg1WritebackEnable_i, FXReg2WritebackEnable_i,
               FXReg1WritebackAddress_i, FXReg2WritebackAddress_i,
               FXReg1WritebackValue_i, FXReg2WritebackValue_i,
        input  FPValid_i, FPReg1WritebackEnable_i, FPReg2WritebackEnable_i,
               FPReg1WritebackAddress_i, FPReg2WritebackAddress_i,
               FPReg1WritebackValue_i, FPReg2WritebackValue_i,
        input  LSValid_i, LSReg1WritebackEnable_i, LSReg2WritebackEnable_i,
               LSReg1WritebackAddress_i, LSReg2WritebackAddress_i,
               LSReg1WritebackValue_i, LSReg2WritebackValue_i,
        output FXReady_o, FPReady_o, LSReady_o,
        output writebackValid_o, functionalUnitCode_o,
               reg1WritebackEnable_o, reg2WritebackEnable_o,
               reg1WritebackAddress_o, reg2WritebackAddress_o,
               reg1WritebackVal_o, reg2WritebackVal_o
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the register-file writeback path between the FX, FP and LS units.
// Each unit owns a one-entry holding buffer; the winner is registered onto the writeback outputs.
module writeback_arbiter #(
    parameter int regWidth     = 6,
    parameter int dataWidth    = 64,
    parameter int FXUnitCode   = 0,
    parameter int FPUnitCode   = 1,
    parameter int LdStUnitCode = 2
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               flush_i,
    writeback_arbiter_if.slave bus
);
    typedef struct packed {
        logic                 en1;
        logic                 en2;
        logic [regWidth-1:0]  addr1;
        logic [regWidth-1:0]  addr2;
        logic [dataWidth-1:0] val1;
        logic [dataWidth-1:0] val2;
    } payload_t;

    localparam logic [1:0] FX_CODE = 2'(FXUnitCode);
    localparam logic [1:0] FP_CODE = 2'(FPUnitCode);
    localparam logic [1:0] LS_CODE = 2'(LdStUnitCode);

    // Unit index 0 = FX, 1 = FP, 2 = LS; the rotation wraps LS back to FX.
    function automatic logic [1:0] wrap_inc(input logic [1:0] u);
        wrap_inc = (u == 2'd2) ? 2'd0 : (u + 2'd1);
    endfunction

    logic [2:0]  offer_s;
    logic [2:0]  ready_s;
    logic [2:0]  accept_s;
    logic [2:0]  grant_s;
    logic [2:0]  held_r;
    payload_t    in_pl_s   [3];
    payload_t    held_pl_r [3];
    payload_t    grant_pl_s;
    logic [1:0]  prio_r;
    logic [1:0]  cand1_s;
    logic [1:0]  cand2_s;
    logic [1:0]  grant_idx_s;
    logic        grant_any_s;
    logic [1:0]  grant_code_s;

    logic                 out_valid_r;
    logic [1:0]           out_code_r;
    logic                 out_en1_r;
    logic                 out_en2_r;
    logic [regWidth-1:0]  out_addr1_r;
    logic [regWidth-1:0]  out_addr2_r;
    logic [dataWidth-1:0] out_val1_r;
    logic [dataWidth-1:0] out_val2_r;

    // Gather the per-unit offers into indexable form.
    always_comb begin
        offer_s    = {bus.LSValid_i, bus.FPValid_i, bus.FXValid_i};
        in_pl_s[0] = {bus.FXReg1WritebackEnable_i, bus.FXReg2WritebackEnable_i,
                      bus.FXReg1WritebackAddress_i, bus.FXReg2WritebackAddress_i,
                      bus.FXReg1WritebackValue_i, bus.FXReg2WritebackValue_i};
        in_pl_s[1] = {bus.FPReg1WritebackEnable_i, bus.FPReg2WritebackEnable_i,
                      bus.FPReg1WritebackAddress_i, bus.FPReg2WritebackAddress_i,
                      bus.FPReg1WritebackValue_i, bus.FPReg2WritebackValue_i};
        in_pl_s[2] = {bus.LSReg1WritebackEnable_i, bus.LSReg2WritebackEnable_i,
                      bus.LSReg1WritebackAddress_i, bus.LSReg2WritebackAddress_i,
                      bus.LSReg1WritebackValue_i, bus.LSReg2WritebackValue_i};
    end

    // Round-robin pick among held entries, starting at prio_r; a flush suppresses any grant.
    always_comb begin
        cand1_s     = wrap_inc(prio_r);
        cand2_s     = wrap_inc(cand1_s);
        grant_any_s = 1'b0;
        grant_idx_s = 2'd0;
        grant_s     = 3'b000;
        if (flush_i) begin
            grant_any_s = 1'b0;
        end else if (held_r[prio_r]) begin
            grant_any_s = 1'b1;
            grant_idx_s = prio_r;
        end else if (held_r[cand1_s]) begin
            grant_any_s = 1'b1;
            grant_idx_s = cand1_s;
        end else if (held_r[cand2_s]) begin
            grant_any_s = 1'b1;
            grant_idx_s = cand2_s;
        end else begin
            grant_any_s = 1'b0;
        end
        if (grant_any_s) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = 3'b000;
        end
        grant_pl_s = held_pl_r[grant_idx_s];
        case (grant_idx_s)
            2'd0:    grant_code_s = FX_CODE;
            2'd1:    grant_code_s = FP_CODE;
            default: grant_code_s = LS_CODE;
        endcase
    end

    assign ready_s  = flush_i ? 3'b000 : (~held_r | grant_s);
    assign accept_s = offer_s & ready_s;

    assign bus.FXReady_o = ready_s[0];
    assign bus.FPReady_o = ready_s[1];
    assign bus.LSReady_o = ready_s[2];

    // Holding buffers: a same-cycle refill wins over the grant clearing the entry.
    always_ff @(posedge clock_i) begin
        for (int u = 0; u < 3; u++) begin
            if (reset_i) begin
                held_r[u]    <= 1'b0;
                held_pl_r[u] <= '0;
            end else if (flush_i) begin
                held_r[u]    <= 1'b0;
            end else if (accept_s[u]) begin
                held_r[u]    <= 1'b1;
                held_pl_r[u] <= in_pl_s[u];
            end else if (grant_s[u]) begin
                held_r[u]    <= 1'b0;
            end else begin
                held_r[u]    <= held_r[u];
            end
        end
    end

    // Priority pointer: next search starts just after the last granted unit.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            prio_r <= 2'd0;
        end else if (grant_any_s) begin
            prio_r <= wrap_inc(grant_idx_s);
        end else begin
            prio_r <= prio_r;
        end
    end

    // Writeback output registers; addresses and values hold when nothing is granted.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            out_valid_r <= 1'b0;
            out_code_r  <= 2'd0;
            out_en1_r   <= 1'b0;
            out_en2_r   <= 1'b0;
            out_addr1_r <= '0;
            out_addr2_r <= '0;
            out_val1_r  <= '0;
            out_val2_r  <= '0;
        end else if (grant_any_s) begin
            out_valid_r <= 1'b1;
            out_code_r  <= grant_code_s;
            out_en1_r   <= grant_pl_s.en1;
            out_en2_r   <= grant_pl_s.en2;
            out_addr1_r <= grant_pl_s.addr1;
            out_addr2_r <= grant_pl_s.addr2;
            out_val1_r  <= grant_pl_s.val1;
            out_val2_r  <= grant_pl_s.val2;
        end else begin
            out_valid_r <= 1'b0;
            out_en1_r   <= 1'b0;
            out_en2_r   <= 1'b0;
        end
    end

    assign bus.writebackValid_o      = out_valid_r;
    assign bus.functionalUnitCode_o  = out_code_r;
    assign bus.reg1WritebackEnable_o = out_en1_r;
    assign bus.reg2WritebackEnable_o = out_en2_r;
    assign bus.reg1WritebackAddress_o = out_addr1_r;
    assign bus.reg2WritebackAddress_o = out_addr2_r;
    assign bus.reg1WritebackVal_o    = out_val1_r;
    assign bus.reg2WritebackVal_o    = out_val2_r;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized bench for writeback_arbiter: a behavioural model predicts readies and the
// sequence of granted results, a monitor pops the scoreboard whenever the DUT emits.
module tb_writeback_arbiter;
    localparam int RW = 6;
    localparam int DW = 64;

    typedef struct packed {
        logic          en1;
        logic          en2;
        logic [RW-1:0] a1;
        logic [RW-1:0] a2;
        logic [DW-1:0] v1;
        logic [DW-1:0] v2;
    } pl_t;

    typedef struct packed {
        logic [1:0] code;
        pl_t        pl;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    logic [2:0] drv_valid;
    pl_t        drv_pl [3];
    logic [2:0] dut_ready;

    logic [2:0] nx_valid;
    pl_t        nx_pl [3];
    logic       nx_flush;
    logic       nx_rst;

    bit         m_held [3];
    pl_t        m_pl [3];
    int         m_ptr;
    exp_t       sb [$];
    bit         mon_en;
    bit         exp_reset_edge;
    pl_t        last_pl;
    int         n_checks;
    int         n_err;
    string      unit_name [3] = '{"FX", "FP", "LS"};

    writeback_arbiter_if #(.regWidth(RW), .dataWidth(DW)) bus ();

    writeback_arbiter #(
        .regWidth(RW), .dataWidth(DW),
        .FXUnitCode(0), .FPUnitCode(1), .LdStUnitCode(2)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .flush_i (flush),
        .bus     (bus.slave)
    );

    assign bus.FXValid_i                = drv_valid[0];
    assign bus.FXReg1WritebackEnable_i  = drv_pl[0].en1;
    assign bus.FXReg2WritebackEnable_i  = drv_pl[0].en2;
    assign bus.FXReg1WritebackAddress_i = drv_pl[0].a1;
    assign bus.FXReg2WritebackAddress_i = drv_pl[0].a2;
    assign bus.FXReg1WritebackValue_i   = drv_pl[0].v1;
    assign bus.FXReg2WritebackValue_i   = drv_pl[0].v2;
    assign bus.FPValid_i                = drv_valid[1];
    assign bus.FPReg1WritebackEnable_i  = drv_pl[1].en1;
    assign bus.FPReg2WritebackEnable_i  = drv_pl[1].en2;
    assign bus.FPReg1WritebackAddress_i = drv_pl[1].a1;
    assign bus.FPReg2WritebackAddress_i = drv_pl[1].a2;
    assign bus.FPReg1WritebackValue_i   = drv_pl[1].v1;
    assign bus.FPReg2WritebackValue_i   = drv_pl[1].v2;
    assign bus.LSValid_i                = drv_valid[2];
    assign bus.LSReg1WritebackEnable_i  = drv_pl[2].en1;
    assign bus.LSReg2WritebackEnable_i  = drv_pl[2].en2;
    assign bus.LSReg1WritebackAddress_i = drv_pl[2].a1;
    assign bus.LSReg2WritebackAddress_i = drv_pl[2].a2;
    assign bus.LSReg1WritebackValue_i   = drv_pl[2].v1;
    assign bus.LSReg2WritebackValue_i   = drv_pl[2].v2;
    assign dut_ready = {bus.LSReady_o, bus.FPReady_o, bus.FXReady_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic pl_t rand_pl();
        pl_t p;
        p.en1 = 1'($urandom);
        p.en2 = 1'($urandom);
        p.a1  = 6'($urandom);
        p.a2  = 6'($urandom);
        p.v1  = {$urandom, $urandom};
        p.v2  = {$urandom, $urandom};
        return p;
    endfunction

    // One cycle: apply the next inputs at the falling edge, then advance the model past the rising edge.
    task automatic step();
        int   g;
        logic [2:0] exp_rdy;
        @(negedge clk);
        drv_valid = nx_valid;
        for (int u = 0; u < 3; u++) drv_pl[u] = nx_pl[u];
        flush = nx_flush;
        rst   = nx_rst;
        #1;
        exp_reset_edge = rst;
        if (rst) begin
            mon_en = 1'b1;
            for (int u = 0; u < 3; u++) m_held[u] = 1'b0;
            m_ptr = 0;
        end else begin
            g = -1;
            if (!flush) begin
                for (int i = 0; i < 3; i++) begin
                    int u;
                    u = (m_ptr + i) % 3;
                    if (g < 0 && m_held[u]) g = u;
                end
            end
            for (int u = 0; u < 3; u++) begin
                exp_rdy[u] = !flush && (!m_held[u] || g == u);
                chk($sformatf("ready_%s", unit_name[u]), 64'(dut_ready[u]), 64'(exp_rdy[u]));
            end
            if (g >= 0) begin
                exp_t e;
                e.code = 2'(g);
                e.pl   = m_pl[g];
                sb.push_back(e);
                m_ptr     = (g + 1) % 3;
                m_held[g] = 1'b0;
            end
            for (int u = 0; u < 3; u++) begin
                if (drv_valid[u] && exp_rdy[u]) begin
                    m_held[u] = 1'b1;
                    m_pl[u]   = drv_pl[u];
                end
            end
            if (flush) begin
                for (int u = 0; u < 3; u++) m_held[u] = 1'b0;
            end
        end
    endtask

    // Monitor: compare every emitted result against the scoreboard head.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (exp_reset_edge) begin
                chk("rst_valid", 64'(bus.writebackValid_o), 64'd0);
                chk("rst_code", 64'(bus.functionalUnitCode_o), 64'd0);
                chk("rst_en1", 64'(bus.reg1WritebackEnable_o), 64'd0);
                chk("rst_en2", 64'(bus.reg2WritebackEnable_o), 64'd0);
                chk("rst_addr1", 64'(bus.reg1WritebackAddress_o), 64'd0);
                chk("rst_addr2", 64'(bus.reg2WritebackAddress_o), 64'd0);
                chk("rst_val1", bus.reg1WritebackVal_o, 64'd0);
                chk("rst_val2", bus.reg2WritebackVal_o, 64'd0);
                last_pl = '0;
            end else if (bus.writebackValid_o) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_output: got valid code %0d expected no output",
                             bus.functionalUnitCode_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("code", 64'(bus.functionalUnitCode_o), 64'(e.code));
                    chk("en1", 64'(bus.reg1WritebackEnable_o), 64'(e.pl.en1));
                    chk("en2", 64'(bus.reg2WritebackEnable_o), 64'(e.pl.en2));
                    chk("addr1", 64'(bus.reg1WritebackAddress_o), 64'(e.pl.a1));
                    chk("addr2", 64'(bus.reg2WritebackAddress_o), 64'(e.pl.a2));
                    chk("val1", bus.reg1WritebackVal_o, e.pl.v1);
                    chk("val2", bus.reg2WritebackVal_o, e.pl.v2);
                    last_pl = e.pl;
                end
            end else begin
                chk("idle_en1", 64'(bus.reg1WritebackEnable_o), 64'd0);
                chk("idle_en2", 64'(bus.reg2WritebackEnable_o), 64'd0);
                chk("idle_addr1_hold", 64'(bus.reg1WritebackAddress_o), 64'(last_pl.a1));
                chk("idle_val2_hold", bus.reg2WritebackVal_o, last_pl.v2);
                chk("missing_output", 64'(sb.size()), 64'd0);
            end
        end
    end

    task automatic idle(input int n);
        nx_valid = 3'b000;
        nx_flush = 1'b0;
        nx_rst   = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        mon_en   = 1'b0;
        exp_reset_edge = 1'b0;
        last_pl  = '0;
        m_ptr    = 0;
        for (int u = 0; u < 3; u++) begin
            m_held[u] = 1'b0;
            m_pl[u]   = '0;
            nx_pl[u]  = '0;
            drv_pl[u] = '0;
        end
        drv_valid = 3'b000;
        flush     = 1'b0;
        rst       = 1'b1;
        nx_valid  = 3'b000;
        nx_flush  = 1'b0;
        nx_rst    = 1'b1;
        step();
        step();

        // Single FX result.
        nx_rst   = 1'b0;
        nx_valid = 3'b001;
        nx_pl[0] = '{en1: 1'b1, en2: 1'b0, a1: 6'd5, a2: 6'd0, v1: 64'h1234, v2: 64'd0};
        step();
        idle(3);

        // All three units continuously valid from reset: codes 0,1,2,...
        nx_rst = 1'b1;
        step();
        nx_rst   = 1'b0;
        nx_valid = 3'b111;
        for (int i = 0; i < 9; i++) begin
            for (int u = 0; u < 3; u++) nx_pl[u] = rand_pl();
            step();
        end

        // Reset while all buffers are held and output is valid; first grant afterwards is FX.
        nx_rst = 1'b1;
        step();
        nx_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int u = 0; u < 3; u++) nx_pl[u] = rand_pl();
            step();
        end
        idle(3);

        // LS alone, four back-to-back results.
        for (int i = 1; i <= 4; i++) begin
            nx_valid = 3'b100;
            nx_pl[2] = rand_pl();
            nx_pl[2].v1 = 64'(i);
            step();
        end
        idle(2);

        // FX and LS held, then flushed before either is granted.
        nx_valid = 3'b101;
        nx_pl[0] = rand_pl();
        nx_pl[2] = rand_pl();
        step();
        nx_valid = 3'b101;
        nx_flush = 1'b1;
        step();
        idle(3);

        // FP result with both enables clear is still emitted.
        nx_valid = 3'b010;
        nx_pl[1] = rand_pl();
        nx_pl[1].en1 = 1'b0;
        nx_pl[1].en2 = 1'b0;
        step();
        idle(2);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            for (int u = 0; u < 3; u++) begin
                nx_valid[u] = ($urandom_range(0, 9) < 6);
                nx_pl[u]    = rand_pl();
            end
            nx_flush = ($urandom_range(0, 24) == 0);
            nx_rst   = ($urandom_range(0, 99) == 0);
            step();
        end
        idle(4);

        @(posedge clk);
        #2;
        chk("final_pending", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
